// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix encodings and burst length helper.
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    localparam int unsigned MAX_PORTS = 4;

    // Beats remaining after the NONSEQ address phase of a new burst.
    function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst,
                                                input int unsigned incr_max);
        logic [3:0] v_len;
        v_len = 4'd0;
        case (hburst_e'(hburst))
            HB_SINGLE:           v_len = 4'd0;
            HB_INCR:             v_len = (incr_max == 0) ? 4'd0 : 4'(incr_max - 1);
            HB_WRAP4, HB_INCR4:   v_len = 4'd3;
            HB_WRAP8, HB_INCR8:   v_len = 4'd7;
            HB_WRAP16, HB_INCR16: v_len = 4'd15;
            default:             v_len = 4'd0;
        endcase
        return v_len;
    endfunction

endpackage

// File: rtl/ahb_out_arb_rr_if.sv
// Request and muxed address-phase signals between output stage and arbiter.
interface ahb_out_arb_rr_if;
    logic       req_port0;
    logic       req_port1;
    logic       req_port2;
    logic       req_port3;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;

    modport master (
        output req_port0, req_port1, req_port2, req_port3,
        output HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port
    );

    modport slave (
        input  req_port0, req_port1, req_port2, req_port3,
        input  HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port
    );
endinterface

// File: rtl/ahb_rr_pick.sv
// Rotate-priority encoder: first request after the pointer wins, pointer itself last.
module ahb_rr_pick
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [1:0] o_winner,
    output logic       o_any_req
);

    logic [3:0] w_req_valid;

    for (genvar g = 0; g < int'(MAX_PORTS); g++) begin : g_mask
        if (g < NUM_PORTS) begin : g_on
            assign w_req_valid[g] = i_req[g];
        end else begin : g_off
            assign w_req_valid[g] = 1'b0;
        end
    end

    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        int unsigned v_idx;
        v_idx     = 0;
        o_winner  = i_ptr;
        o_any_req = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            v_idx = (int'(i_ptr) + k) % NUM_PORTS;
            if (w_req_valid[v_idx[1:0]]) begin
                o_winner  = v_idx[1:0];
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_out_arb_rr.sv
// Round-robin address-phase arbiter for one bus-matrix output stage.
module ahb_out_arb_rr
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int INCR_MAX_BEATS = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_out_arb_rr_if.slave   bus
);

    logic [3:0] r_beat_cnt;
    logic [1:0] r_addr_in_port;
    logic       r_no_port;

    logic [3:0] w_req;
    logic [3:0] w_rem_next;
    logic       w_addr_xfer;
    logic       w_hold;
    logic [1:0] w_winner;
    logic       w_any_req;

    assign w_req = {bus.req_port3, bus.req_port2, bus.req_port1, bus.req_port0};

    ahb_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .i_req     (w_req),
        .i_ptr     (r_addr_in_port),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // A deselected port ends any burst in flight, whatever HTRANS says.
    always_comb begin
        w_rem_next = 4'd0;
        if (bus.HSELM) begin
            case (htrans_e'(bus.HTRANSM))
                HT_IDLE:   w_rem_next = 4'd0;
                HT_BUSY:   w_rem_next = r_beat_cnt;
                HT_NONSEQ: w_rem_next = burst_len_m1(bus.HBURSTM, INCR_MAX_BEATS);
                HT_SEQ:    w_rem_next = (r_beat_cnt == 4'd0) ? 4'd0 : r_beat_cnt - 4'd1;
                default:   w_rem_next = 4'd0;
            endcase
        end
    end

    assign w_addr_xfer = bus.HSELM & bus.HTRANSM[1] & bus.HREADYM;
    assign w_hold      = bus.HMASTLOCKM
                       | (bus.HSELM & (bus.HTRANSM == HT_BUSY))
                       | (w_addr_xfer & (w_rem_next != 4'd0));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_beat_cnt     <= 4'd0;
            r_addr_in_port <= 2'd0;
            r_no_port      <= 1'b1;
        end else if (bus.HREADYM) begin
            r_beat_cnt <= w_rem_next;
            if (w_hold) begin
                r_no_port <= 1'b0;
            end else if (w_any_req) begin
                r_addr_in_port <= w_winner;
                r_no_port      <= 1'b0;
            end else begin
                // Keep the last index so the round-robin pointer survives idle periods.
                r_no_port <= 1'b1;
            end
        end
    end

    assign bus.addr_in_port = r_addr_in_port;
    assign bus.no_port      = r_no_port;

endmodule

// File: tb/tb_ahb_out_arb_rr.sv
// Self-checking bench: three arbiter configurations against a behavioural model.
module tb_ahb_out_arb_rr;
    import ahb_mtx_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] t_req;
    logic       t_hready;
    logic       t_hsel;
    logic [1:0] t_trans;
    logic [2:0] t_burst;
    logic       t_lock;

    int n_cmp;
    int n_bad;

    // cfg0: 4 ports, INCR=0; cfg1: 4 ports, INCR=4; cfg2: 3 ports, INCR=0
    int cfg_n[3]   = '{4, 4, 3};
    int cfg_imb[3] = '{0, 4, 0};
    int m_port[3];
    int m_nop[3];
    int m_cnt[3];

    logic [1:0] got_port[3];
    logic       got_nop[3];

    ahb_out_arb_rr_if if_a ();
    ahb_out_arb_rr_if if_b ();
    ahb_out_arb_rr_if if_c ();

    ahb_out_arb_rr #(.NUM_PORTS(4), .INCR_MAX_BEATS(0)) dut_a (.HCLK(clk), .HRESETn(rst_n), .bus(if_a));
    ahb_out_arb_rr #(.NUM_PORTS(4), .INCR_MAX_BEATS(4)) dut_b (.HCLK(clk), .HRESETn(rst_n), .bus(if_b));
    ahb_out_arb_rr #(.NUM_PORTS(3), .INCR_MAX_BEATS(0)) dut_c (.HCLK(clk), .HRESETn(rst_n), .bus(if_c));

    assign {if_a.req_port3, if_a.req_port2, if_a.req_port1, if_a.req_port0} = t_req;
    assign {if_b.req_port3, if_b.req_port2, if_b.req_port1, if_b.req_port0} = t_req;
    assign {if_c.req_port3, if_c.req_port2, if_c.req_port1, if_c.req_port0} = t_req;
    assign if_a.HREADYM = t_hready;  assign if_b.HREADYM = t_hready;  assign if_c.HREADYM = t_hready;
    assign if_a.HSELM   = t_hsel;    assign if_b.HSELM   = t_hsel;    assign if_c.HSELM   = t_hsel;
    assign if_a.HTRANSM = t_trans;   assign if_b.HTRANSM = t_trans;   assign if_c.HTRANSM = t_trans;
    assign if_a.HBURSTM = t_burst;   assign if_b.HBURSTM = t_burst;   assign if_c.HBURSTM = t_burst;
    assign if_a.HMASTLOCKM = t_lock; assign if_b.HMASTLOCKM = t_lock; assign if_c.HMASTLOCKM = t_lock;

    assign got_port[0] = if_a.addr_in_port;  assign got_nop[0] = if_a.no_port;
    assign got_port[1] = if_b.addr_in_port;  assign got_nop[1] = if_b.no_port;
    assign got_port[2] = if_c.addr_in_port;  assign got_nop[2] = if_c.no_port;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int burst_beats(input logic [2:0] hb, input int imb);
        case (hb)
            3'd0:       return 1;
            3'd1:       return (imb == 0) ? 1 : imb;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_port[c] = 0;
            m_nop[c]  = 1;
            m_cnt[c]  = 0;
        end
    endtask

    // Behavioural view: remaining beats as an integer, grant by scanning ports after the current one.
    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            int  rem;
            bit  hold;
            bit  found;
            if (t_hready) begin
                if (!t_hsel || t_trans == HT_IDLE)  rem = 0;
                else if (t_trans == HT_BUSY)        rem = m_cnt[c];
                else if (t_trans == HT_NONSEQ)      rem = burst_beats(t_burst, cfg_imb[c]) - 1;
                else                                rem = (m_cnt[c] > 0) ? m_cnt[c] - 1 : 0;
                hold = t_lock || (t_hsel && t_trans == HT_BUSY) || (t_hsel && t_trans[1] && rem > 0);
                m_cnt[c] = rem;
                if (hold) begin
                    m_nop[c] = 0;
                end else begin
                    found = 0;
                    for (int k = 1; k <= cfg_n[c]; k++) begin
                        int p;
                        p = (m_port[c] + k) % cfg_n[c];
                        if (!found && t_req[p]) begin
                            found = 1;
                            m_port[c] = p;
                        end
                    end
                    m_nop[c] = found ? 0 : 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic hsel, input logic [1:0] tr,
                         input logic [2:0] hb, input logic lk);
        t_req   = req;
        t_hsel  = hsel;
        t_trans = tr;
        t_burst = hb;
        t_lock  = lk;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        t_hready = 1'b1;
        drive(4'b0000, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (got_port[c] !== 2'd0 || got_nop[c] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL reset_idle cfg%0d cyc%0d: got port=%0d no_port=%0b, want port=0 no_port=1",
                             c, i, got_port[c], got_nop[c]);
                end
            end
        end
    endtask

    task automatic test_rr_fairness();
        int exp4[5] = '{1, 2, 3, 0, 1};
        int exp3[5] = '{1, 2, 0, 1, 2};
        drive(4'b1111, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                int e;
                e = (c == 2) ? exp3[i] : exp4[i];
                n_cmp++;
                if (got_port[c] !== 2'(e) || got_nop[c] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rr_fairness cfg%0d grant%0d: got port=%0d no_port=%0b, want port=%0d no_port=0",
                             c, i, got_port[c], got_nop[c], e);
                end
            end
        end
    endtask

    task automatic test_incr8_hold();
        drive(4'b0100, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(4'b0101, 1'b1, (i == 1) ? HT_NONSEQ : HT_SEQ, HB_INCR8, 1'b0);
            tick();
            for (int c = 0; c < 3; c++) begin
                int e;
                e = (i < 8) ? 2 : 0;
                n_cmp++;
                if (got_port[c] !== 2'(e) || got_nop[c] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL incr8_hold cfg%0d beat%0d: got port=%0d no_port=%0b, want port=%0d no_port=0",
                             c, i, got_port[c], got_nop[c], e);
                end
            end
        end
    endtask

    task automatic test_wait_early_term();
        drive(4'b0010, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
        tick();
        drive(4'b1010, 1'b1, HT_NONSEQ, HB_INCR4, 1'b0);
        tick();
        drive(4'b1010, 1'b1, HT_SEQ, HB_INCR4, 1'b0);
        tick();
        t_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (got_port[c] !== 2'd1 || got_nop[c] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wait_hold cfg%0d wait%0d: got port=%0d no_port=%0b, want port=1 no_port=0",
                             c, i, got_port[c], got_nop[c]);
                end
            end
        end
        t_hready = 1'b1;
        drive(4'b1010, 1'b1, HT_IDLE, HB_INCR4, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            int e;
            e = (c == 2) ? 1 : 3;
            n_cmp++;
            if (got_port[c] !== 2'(e) || got_nop[c] !== 1'b0) begin
                n_bad++;
                $display("FAIL early_term cfg%0d: got port=%0d no_port=%0b, want port=%0d no_port=0",
                         c, got_port[c], got_nop[c], e);
            end
        end
    endtask

    task automatic test_lock();
        drive(4'b0010, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1010, 1'b1, (i < 2) ? HT_NONSEQ : HT_IDLE, HB_SINGLE, (i < 3) ? 1'b1 : 1'b0);
            tick();
            for (int c = 0; c < 3; c++) begin
                int e;
                e = (i == 3 && c != 2) ? 3 : 1;
                n_cmp++;
                if (got_port[c] !== 2'(e) || got_nop[c] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lock cfg%0d step%0d: got port=%0d no_port=%0b, want port=%0d no_port=0",
                             c, i, got_port[c], got_nop[c], e);
                end
            end
        end
    endtask

    task automatic test_incr_max();
        int expb[4] = '{0, 0, 0, 1};
        drive(4'b0001, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
        tick();
        for (int i = 1; i <= 6; i++) begin
            drive(4'b0011, 1'b1, (i == 1) ? HT_NONSEQ : HT_SEQ, HB_INCR, 1'b0);
            tick();
            if (i <= 4) begin
                n_cmp++;
                if (got_port[1] !== 2'(expb[i-1]) || got_nop[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL incr_max beat%0d: got port=%0d no_port=%0b, want port=%0d no_port=0",
                             i, got_port[1], got_nop[1], expb[i-1]);
                end
            end
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (got_port[c] !== 2'(m_port[c]) || got_nop[c] !== 1'(m_nop[c])) begin
                    n_bad++;
                    $display("FAIL incr_model cfg%0d beat%0d: got port=%0d no_port=%0b, want port=%0d no_port=%0d",
                             c, i, got_port[c], got_nop[c], m_port[c], m_nop[c]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(4'b1000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
        tick();
        drive(4'b1001, 1'b1, HT_NONSEQ, HB_INCR8, 1'b0);
        tick();
        drive(4'b1001, 1'b1, HT_SEQ, HB_INCR8, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (got_port[c] !== 2'd0 || got_nop[c] !== 1'b1) begin
                n_bad++;
                $display("FAIL async_reset cfg%0d: got port=%0d no_port=%0b, want port=0 no_port=1",
                         c, got_port[c], got_nop[c]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            t_hready = ($urandom_range(0, 9) < 8);
            t_req    = 4'($urandom_range(0, 15));
            t_hsel   = ($urandom_range(0, 9) < 8);
            t_trans  = 2'($urandom);
            t_burst  = 3'($urandom);
            t_lock   = ($urandom_range(0, 9) == 0);
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (got_port[c] !== 2'(m_port[c]) || got_nop[c] !== 1'(m_nop[c])) begin
                    n_bad++;
                    $display("FAIL random cfg%0d cyc%0d: got port=%0d no_port=%0b, want port=%0d no_port=%0d",
                             c, i, got_port[c], got_nop[c], m_port[c], m_nop[c]);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_rr_fairness();
        test_incr8_hold();
        test_wait_early_term();
        test_lock();
        test_incr_max();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
